// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray/binary helpers for the Gray receive monitor
package gray_pkg;

    typedef enum logic [1:0] {HOLD, STEP, BAD} step_e;
    typedef enum logic {SEARCH, LOCKED} state_e;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    // Zero-extended inputs decode correctly because the upper Gray bits are 0.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_rx_monitor_sync.sv
// rtl/gray_rx_monitor_sync.sv - reset-to-0 synchronizer chain with a matching valid path
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_data  = i_data;
            assign o_valid = 1'b1;
        end else begin : g_chain
            logic [WIDTH-1:0]  r_data [STAGES];
            logic [STAGES-1:0] r_valid;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_data[i] <= '0;
                    end
                    r_valid <= '0;
                end else begin
                    r_data[0] <= i_data;
                    for (int i = 1; i < STAGES; i++) begin
                        r_data[i] <= r_data[i-1];
                    end
                    r_valid <= (r_valid << 1) | STAGES'(1);
                end
            end

            assign o_data  = r_data[STAGES-1];
            assign o_valid = r_valid[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/gray_rx_monitor.sv
// rtl/gray_rx_monitor.sv - Gray counter receiver: sync, decode, step check, lock and error count
module gray_rx_monitor
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] gray_in,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  bin_valid,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [7:0]            err_count
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    logic [DATA_WIDTH-1:0] w_sync_data;
    logic                  w_sync_valid;
    logic [DATA_WIDTH-1:0] w_dec;
    logic [DATA_WIDTH-1:0] w_prev_inc;
    logic                  w_classify;
    step_e                 w_step;

    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_have_prev;
    logic [CNT_W-1:0]      r_lock_cnt;
    state_e                r_state;

    gray_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_data  (gray_in),
        .o_data  (w_sync_data),
        .o_valid (w_sync_valid)
    );

    assign w_dec = DATA_WIDTH'(gray2bin(32'(w_sync_data)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bin_out   <= '0;
            bin_valid <= 1'b0;
        end else begin
            bin_out   <= w_dec;
            bin_valid <= w_sync_valid;
        end
    end

    // Modulo increment makes the all-ones to zero wrap a legal step.
    assign w_prev_inc = r_prev + DATA_WIDTH'(1);
    assign w_classify = bin_valid & r_have_prev;

    always_comb begin
        w_step = BAD;
        if (bin_out == r_prev) begin
            w_step = HOLD;
        end else if (bin_out == w_prev_inc) begin
            w_step = STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_lock_cnt  <= '0;
            r_state     <= SEARCH;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bin_valid) begin
                r_prev      <= bin_out;
                r_have_prev <= 1'b1;
            end
            if (w_classify) begin
                case (r_state)
                    SEARCH: begin
                        if (w_step == STEP) begin
                            if (r_lock_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                                r_state    <= LOCKED;
                                locked     <= 1'b1;
                                r_lock_cnt <= '0;
                            end else begin
                                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
                            end
                        end else if (w_step == BAD) begin
                            r_lock_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_step == BAD) begin
                            r_state    <= SEARCH;
                            locked     <= 1'b0;
                            r_lock_cnt <= '0;
                            err_pulse  <= 1'b1;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
